// File: rtl/rank_display.sv
`default_nettype none
// ============================================================================
//  Module   : rank_display
//  Purpose  : Snapshots the packed 5-player rank bus and cycles the display
//             through ranked players in (rank, index) order, flagging the winner.
//  Revision : 1.0 - initial release
// ============================================================================
module rank_display #(
    parameter int HOLD_CYCLES = 8
) (
    input  logic        m_clock,
    input  logic        p_reset,
    input  logic [24:0] RANK_IN,
    input  logic        clear,
    output logic [4:0]  WIN_LED,
    output logic [2:0]  DISP_PLAYER,
    output logic [4:0]  DISP_RANK,
    output logic        VALID
);
    localparam int                  c_HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [2:0]          c_LAST_IDX  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_SHOW = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [24:0]         r_snap;
    logic [2:0]          r_idx;
    logic [c_HOLD_W-1:0] r_hold;
    // Keys are {rank, index}: a plain unsigned compare gives lexicographic order.
    logic [7:0]          r_cur_key, r_next_key, r_min_key;
    logic                r_cur_ok, r_next_ok, r_min_ok;
    logic [4:0]          r_win_led;
    logic [2:0]          r_disp_player;
    logic [4:0]          r_disp_rank;
    logic                r_valid;

    logic [4:0]          w_field;
    logic [7:0]          w_key;
    logic                w_hit, w_min_upd, w_next_upd;
    logic                w_min_ok, w_next_ok;
    logic [7:0]          w_min_key, w_next_key, w_pick;
    logic                w_rank_any;

    always_comb begin
        w_field = 5'd0;
        case (r_idx)
            3'd0:    w_field = r_snap[4:0];
            3'd1:    w_field = r_snap[9:5];
            3'd2:    w_field = r_snap[14:10];
            3'd3:    w_field = r_snap[19:15];
            3'd4:    w_field = r_snap[24:20];
            default: w_field = 5'd0;
        endcase
    end

    assign w_rank_any = |RANK_IN;
    assign w_key      = {w_field, r_idx};
    assign w_hit      = |w_field;
    assign w_min_upd  = w_hit && (!r_min_ok || (w_key < r_min_key));
    assign w_next_upd = w_hit && (!r_cur_ok || (w_key > r_cur_key))
                              && (!r_next_ok || (w_key < r_next_key));
    assign w_min_ok   = r_min_ok | w_min_upd;
    assign w_min_key  = w_min_upd ? w_key : r_min_key;
    assign w_next_ok  = r_next_ok | w_next_upd;
    assign w_next_key = w_next_upd ? w_key : r_next_key;
    // No successor above the current entry means wrap back to the minimum.
    assign w_pick     = w_next_ok ? w_next_key : w_min_key;

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_rank_any) w_state_nxt = S_SCAN;
                S_SCAN:  if (r_idx == c_LAST_IDX) w_state_nxt = w_min_ok ? S_SHOW : S_IDLE;
                S_SHOW:  if (r_hold == c_HOLD_LAST) w_state_nxt = S_SCAN;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            r_snap        <= 25'd0;
            r_idx         <= 3'd0;
            r_hold        <= '0;
            r_cur_key     <= 8'd0;
            r_cur_ok      <= 1'b0;
            r_next_key    <= 8'd0;
            r_next_ok     <= 1'b0;
            r_min_key     <= 8'd0;
            r_min_ok      <= 1'b0;
            r_win_led     <= 5'd0;
            r_disp_player <= 3'd0;
            r_disp_rank   <= 5'd0;
            r_valid       <= 1'b0;
        end else if (clear) begin
            r_hold        <= '0;
            r_cur_ok      <= 1'b0;
            r_next_ok     <= 1'b0;
            r_min_ok      <= 1'b0;
            r_win_led     <= 5'd0;
            r_disp_player <= 3'd0;
            r_disp_rank   <= 5'd0;
            r_valid       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_rank_any) begin
                        r_snap    <= RANK_IN;
                        r_idx     <= 3'd0;
                        r_next_ok <= 1'b0;
                        r_min_ok  <= 1'b0;
                        r_cur_ok  <= 1'b0;
                    end
                end
                S_SCAN: begin
                    r_idx      <= r_idx + 3'd1;
                    r_next_ok  <= w_next_ok;
                    r_next_key <= w_next_key;
                    r_min_ok   <= w_min_ok;
                    r_min_key  <= w_min_key;
                    if (r_idx == c_LAST_IDX) begin
                        if (w_min_ok) begin
                            r_cur_key     <= w_pick;
                            r_cur_ok      <= 1'b1;
                            r_hold        <= '0;
                            r_disp_player <= w_pick[2:0] + 3'd1;
                            r_disp_rank   <= w_pick[7:3];
                            r_win_led     <= 5'(5'd1 << w_min_key[2:0]);
                            r_valid       <= 1'b1;
                        end else begin
                            r_cur_ok      <= 1'b0;
                            r_disp_player <= 3'd0;
                            r_disp_rank   <= 5'd0;
                            r_win_led     <= 5'd0;
                            r_valid       <= 1'b0;
                        end
                    end
                end
                S_SHOW: begin
                    // Fresh snapshot each period; the displayed entry (cur) carries over.
                    if (r_hold == c_HOLD_LAST) begin
                        r_snap    <= RANK_IN;
                        r_idx     <= 3'd0;
                        r_next_ok <= 1'b0;
                        r_min_ok  <= 1'b0;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign WIN_LED     = r_win_led;
    assign DISP_PLAYER = r_disp_player;
    assign DISP_RANK   = r_disp_rank;
    assign VALID       = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_rank_display.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rank_display
//  Purpose  : Self-checking bench for rank_display (table vectors + scoreboard).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rank_display;
    localparam int c_HOLD   = 4;
    localparam int c_PERIOD = c_HOLD + 5;

    logic        m_clock = 1'b0;
    logic        p_reset;
    logic        clear;
    logic [24:0] RANK_IN;
    logic [4:0]  WIN_LED;
    logic [2:0]  DISP_PLAYER;
    logic [4:0]  DISP_RANK;
    logic        VALID;

    always #5 m_clock = ~m_clock;

    rank_display #(.HOLD_CYCLES(c_HOLD)) dut (
        .m_clock     (m_clock),
        .p_reset     (p_reset),
        .RANK_IN     (RANK_IN),
        .clear       (clear),
        .WIN_LED     (WIN_LED),
        .DISP_PLAYER (DISP_PLAYER),
        .DISP_RANK   (DISP_RANK),
        .VALID       (VALID)
    );

    int cyc = 0;
    always @(posedge m_clock) cyc <= cyc + 1;

    int ntests = 0;
    int nfail  = 0;

    typedef struct {
        int          cyc;
        logic [13:0] exp;
        string       name;
    } exp_t;

    typedef struct {
        string         name;
        logic [24:0]   rank;
        logic [3:0][7:0] seq;
        logic [4:0]    led;
    } vec_t;

    exp_t sb[$];
    exp_t m_e;
    vec_t vecs[6];

    function automatic logic [13:0] obs();
        return {VALID, DISP_PLAYER, DISP_RANK, WIN_LED};
    endfunction

    function automatic logic [7:0] mk(int p, int r);
        return {3'(p), 5'(r)};
    endfunction

    function automatic logic [24:0] fld(int i, int r);
        return 25'(r) << (5 * i);
    endfunction

    task automatic check(string name, logic [13:0] act, logic [13:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got v=%b p=%0d r=%0d led=%b, expected v=%b p=%0d r=%0d led=%b",
                     name, act[13], act[12:10], act[9:5], act[4:0],
                     exp[13], exp[12:10], exp[9:5], exp[4:0]);
        end
    endtask

    task automatic expect_at(int c, logic v, logic [2:0] p, logic [4:0] r, logic [4:0] led, string name);
        exp_t e;
        int   i;
        e.cyc  = c;
        e.exp  = {v, p, r, led};
        e.name = name;
        i = sb.size();
        while (i > 0 && sb[i-1].cyc > c) i--;
        sb.insert(i, e);
    endtask

    always @(negedge m_clock) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            m_e = sb.pop_front();
            check(m_e.name, obs(), m_e.exp);
        end
    end

    task automatic wait_until(int c);
        while (cyc < c) begin
            @(posedge m_clock);
            #1;
        end
    endtask

    task automatic do_clear();
        int c;
        RANK_IN = 25'd0;
        clear   = 1'b1;
        c = cyc;
        expect_at(c + 1, 1'b0, 3'd0, 5'd0, 5'd0, "clear");
        @(posedge m_clock);
        #1;
        clear = 1'b0;
    endtask

    task automatic set_vec(int i, string name, logic [24:0] rank,
                           logic [7:0] s0, logic [7:0] s1, logic [7:0] s2, logic [7:0] s3,
                           logic [4:0] led);
        vecs[i].name   = name;
        vecs[i].rank   = rank;
        vecs[i].seq[0] = s0;
        vecs[i].seq[1] = s1;
        vecs[i].seq[2] = s2;
        vecs[i].seq[3] = s3;
        vecs[i].led    = led;
    endtask

    task automatic run_vec(vec_t v);
        int n;
        do_clear();
        RANK_IN = v.rank;
        n = cyc;
        expect_at(n + 5, 1'b0, 3'd0, 5'd0, 5'd0, $sformatf("%s_pre", v.name));
        for (int k = 0; k < 4; k++) begin
            expect_at(n + 6 + k * c_PERIOD, 1'b1, v.seq[k][7:5], v.seq[k][4:0], v.led,
                      $sformatf("%s_e%0d", v.name, k));
            if (k < 3)
                expect_at(n + 13 + k * c_PERIOD, 1'b1, v.seq[k][7:5], v.seq[k][4:0], v.led,
                          $sformatf("%s_hold%0d", v.name, k));
        end
        wait_until(n + 7 + 3 * c_PERIOD);
    endtask

    initial begin
        int n;
        int guard;
        p_reset = 1'b0;
        clear   = 1'b0;
        RANK_IN = 25'd0;

        set_vec(0, "single_p2", fld(2, 1),
                mk(3, 1), mk(3, 1), mk(3, 1), mk(3, 1), 5'b00100);
        set_vec(1, "order_wrap", fld(0, 3) | fld(1, 1) | fld(4, 2),
                mk(2, 1), mk(5, 2), mk(1, 3), mk(2, 1), 5'b00010);
        set_vec(2, "tie", fld(1, 2) | fld(3, 2),
                mk(2, 2), mk(4, 2), mk(2, 2), mk(4, 2), 5'b00010);
        set_vec(3, "rank31", fld(4, 31),
                mk(5, 31), mk(5, 31), mk(5, 31), mk(5, 31), 5'b10000);
        set_vec(4, "reverse", fld(0, 5) | fld(1, 4) | fld(2, 3) | fld(3, 2) | fld(4, 1),
                mk(5, 1), mk(4, 2), mk(3, 3), mk(2, 4), 5'b10000);
        set_vec(5, "all_tie", fld(0, 7) | fld(1, 7) | fld(2, 7) | fld(3, 7) | fld(4, 7),
                mk(1, 7), mk(2, 7), mk(3, 7), mk(4, 7), 5'b00001);

        repeat (2) @(posedge m_clock);
        #1;
        check("reset_state", obs(), 14'd0);
        p_reset = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Late arrival: p3 appears during the first SHOW and becomes the next entry.
        do_clear();
        RANK_IN = fld(0, 1);
        n = cyc;
        expect_at(n + 6, 1'b1, 3'd1, 5'd1, 5'b00001, "late_e0");
        wait_until(n + 7);
        RANK_IN = fld(0, 1) | fld(3, 2);
        expect_at(n + 6 + c_PERIOD,     1'b1, 3'd4, 5'd2, 5'b00001, "late_e1");
        expect_at(n + 6 + 2 * c_PERIOD, 1'b1, 3'd1, 5'd1, 5'b00001, "late_e2");
        expect_at(n + 6 + 3 * c_PERIOD, 1'b1, 3'd4, 5'd2, 5'b00001, "late_e3");
        wait_until(n + 7 + 3 * c_PERIOD);

        // clear during SHOW with RANK_IN still active.
        do_clear();
        RANK_IN = vecs[1].rank;
        n = cyc;
        expect_at(n + 6, 1'b1, 3'd2, 5'd1, 5'b00010, "clrshow_e0");
        wait_until(n + 8);
        clear = 1'b1;
        expect_at(n + 9, 1'b0, 3'd0, 5'd0, 5'd0, "clrshow_zero");
        wait_until(n + 9);
        clear = 1'b0;
        expect_at(n + 14, 1'b0, 3'd0, 5'd0, 5'd0, "clrshow_pre");
        expect_at(n + 15, 1'b1, 3'd2, 5'd1, 5'b00010, "clrshow_back");
        wait_until(n + 16);

        // clear on the same edge that completes the first scan.
        do_clear();
        RANK_IN = vecs[1].rank;
        n = cyc;
        wait_until(n + 5);
        clear = 1'b1;
        expect_at(n + 6, 1'b0, 3'd0, 5'd0, 5'd0, "clrscan_zero");
        wait_until(n + 6);
        clear = 1'b0;
        expect_at(n + 11, 1'b0, 3'd0, 5'd0, 5'd0, "clrscan_pre");
        expect_at(n + 12, 1'b1, 3'd2, 5'd1, 5'b00010, "clrscan_back");
        wait_until(n + 14);

        // Asynchronous reset mid-run with RANK_IN idle.
        RANK_IN = 25'd0;
        #2;
        p_reset = 1'b0;
        #1;
        check("async_reset", obs(), 14'd0);
        @(posedge m_clock);
        #1;
        p_reset = 1'b1;
        n = cyc;
        for (int k = 1; k <= 3; k++)
            expect_at(n + k, 1'b0, 3'd0, 5'd0, 5'd0, $sformatf("post_reset%0d", k));
        wait_until(n + 4);

        guard = 0;
        while (sb.size() > 0 && guard < 50) begin
            @(posedge m_clock);
            guard++;
        end
        while (sb.size() > 0) begin
            m_e = sb.pop_front();
            ntests++;
            nfail++;
            $display("FAIL %s: never compared, expected at cycle %0d", m_e.name, m_e.cyc);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
`default_nettype wire
